// File: rtl/panel_pkg.sv
// Shared widths and scanner state encoding for the panel scan path.
package panel_pkg;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_ACK  = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;
  localparam logic [2:0] ST_TICK = 3'd5;

endpackage

// File: rtl/panel_blend8.sv
// Single-channel alpha blend of a panel colour over a background colour.
module panel_blend8
  import panel_pkg::*;
(
  input  logic [COLOR_W-1:0] i_c,
  input  logic [COLOR_W-1:0] i_b,
  input  logic [COLOR_W-1:0] i_a,
  output logic [COLOR_W-1:0] o_y
);

  // (t + t/256) / 256 approximates t/255, exact at alpha 0 and 255.
  function automatic logic [COLOR_W-1:0] blend_round(input logic [16:0] t);
    logic [16:0] s;
    s = t + (t >> 8);
    return s[15:8];
  endfunction

  logic [16:0] w_t;

  assign w_t = ({9'd0, i_c} * {9'd0, i_a}) + ({9'd0, i_b} * {9'd0, ~i_a}) + 17'd128;
  assign o_y = blend_round(w_t);

endmodule

// File: rtl/panel_scan.sv
// Raster scanner: requests pixels from a panel generator, blends them over a
// background colour and streams them to the LED driver.
module panel_scan
  import panel_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int HEIGHT   = 32,
  parameter int TICK_DIV = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [COLOR_W-1:0] bgRed,
  input  logic [COLOR_W-1:0] bgGreen,
  input  logic [COLOR_W-1:0] bgBlue,
  output logic               panelValid,
  output logic               panelTick,
  output logic [COORD_W-1:0] panelX,
  output logic [COORD_W-1:0] panelY,
  output logic               panelAck,
  input  logic               panelValidOut,
  input  logic               panelReady,
  input  logic [COLOR_W-1:0] panelRed,
  input  logic [COLOR_W-1:0] panelGreen,
  input  logic [COLOR_W-1:0] panelBlue,
  input  logic [COLOR_W-1:0] panelAlpha,
  output logic               pixValid,
  input  logic               pixReady,
  output logic [COORD_W-1:0] pixX,
  output logic [COORD_W-1:0] pixY,
  output logic [COLOR_W-1:0] pixRed,
  output logic [COLOR_W-1:0] pixGreen,
  output logic [COLOR_W-1:0] pixBlue,
  output logic               pixTimeout,
  output logic               frameDone
);

  localparam int                 CNT_W     = $clog2(TIMEOUT + 1) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMEOUT);
  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(HEIGHT - 1);
  localparam logic [7:0]         TICK_LAST = 8'(TICK_DIV - 1);

  logic [2:0]         r_state;
  logic [COORD_W-1:0] r_x, r_y;
  logic [7:0]         r_frm;
  logic [CNT_W-1:0]   r_cnt;
  logic [COLOR_W-1:0] r_capR, r_capG, r_capB, r_capA;
  logic               r_tmo;
  logic [COORD_W-1:0] r_pixX, r_pixY;
  logic [COLOR_W-1:0] r_pixR, r_pixG, r_pixB;
  logic               r_pixTmo;

  logic [COLOR_W-1:0] w_blR, w_blG, w_blB;
  logic               w_accept, w_last_x, w_last_y;

  panel_blend8 u_blend_r (.i_c(r_capR), .i_b(bgRed),   .i_a(r_capA), .o_y(w_blR));
  panel_blend8 u_blend_g (.i_c(r_capG), .i_b(bgGreen), .i_a(r_capA), .o_y(w_blG));
  panel_blend8 u_blend_b (.i_c(r_capB), .i_b(bgBlue),  .i_a(r_capA), .o_y(w_blB));

  assign w_accept = (r_state == ST_OUT) && pixReady;
  assign w_last_x = (r_x == X_LAST);
  assign w_last_y = (r_y == Y_LAST);

  // Requests are strobed combinationally so the strobe and the state move agree on panelReady.
  assign panelValid = ((r_state == ST_REQ) || (r_state == ST_TICK)) && panelReady;
  assign panelTick  = (r_state == ST_TICK) && panelReady;
  assign panelX     = r_x;
  assign panelY     = r_y;
  assign panelAck   = (r_state == ST_ACK);
  assign pixValid   = (r_state == ST_OUT);
  assign pixX       = r_pixX;
  assign pixY       = r_pixY;
  assign pixRed     = r_pixR;
  assign pixGreen   = r_pixG;
  assign pixBlue    = r_pixB;
  assign pixTimeout = r_pixTmo;
  assign frameDone  = w_accept && w_last_x && w_last_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_frm    <= '0;
      r_cnt    <= '0;
      r_capR   <= '0;
      r_capG   <= '0;
      r_capB   <= '0;
      r_capA   <= '0;
      r_tmo    <= 1'b0;
      r_pixX   <= '0;
      r_pixY   <= '0;
      r_pixR   <= '0;
      r_pixG   <= '0;
      r_pixB   <= '0;
      r_pixTmo <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (panelReady) begin
            r_cnt   <= CNT_W'(1);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A validOut already high on entry is taken as this request's answer.
          if (panelValidOut) begin
            r_capR  <= panelRed;
            r_capG  <= panelGreen;
            r_capB  <= panelBlue;
            r_capA  <= panelAlpha;
            r_tmo   <= 1'b0;
            r_state <= ST_ACK;
          end else if (r_cnt == CNT_LAST) begin
            r_capR  <= bgRed;
            r_capG  <= bgGreen;
            r_capB  <= bgBlue;
            r_capA  <= '0;
            r_tmo   <= 1'b1;
            r_state <= ST_ACK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_ACK: begin
          r_pixR   <= w_blR;
          r_pixG   <= w_blG;
          r_pixB   <= w_blB;
          r_pixX   <= r_x;
          r_pixY   <= r_y;
          r_pixTmo <= r_tmo;
          r_state  <= ST_OUT;
        end
        ST_OUT: begin
          if (pixReady) begin
            if (w_last_x) begin
              r_x <= '0;
              if (w_last_y) begin
                r_y <= '0;
                if (r_frm == TICK_LAST) begin
                  r_frm   <= '0;
                  r_state <= ST_TICK;
                end else begin
                  r_frm   <= r_frm + 8'd1;
                  r_state <= ST_IDLE;
                end
              end else begin
                r_y     <= r_y + COORD_W'(1);
                r_state <= enable ? ST_REQ : ST_IDLE;
              end
            end else begin
              r_x     <= r_x + COORD_W'(1);
              r_state <= enable ? ST_REQ : ST_IDLE;
            end
          end
        end
        ST_TICK: begin
          if (panelReady) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_panel_scan.sv
// Directed bench for panel_scan with a small responder model of the panel.
module tb_panel_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] bgRed = 8'h20, bgGreen = 8'h20, bgBlue = 8'h20;
  logic       panelValid, panelTick, panelAck;
  logic [9:0] panelX, panelY;
  logic       panelValidOut = 1'b0;
  logic       panelReady = 1'b1;
  logic [7:0] panelRed = 8'h00, panelGreen = 8'h10, panelBlue = 8'h00, panelAlpha = 8'hFF;
  logic       pixValid;
  logic       pixReady = 1'b1;
  logic [9:0] pixX, pixY;
  logic [7:0] pixRed, pixGreen, pixBlue;
  logic       pixTimeout, frameDone;

  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, req_cyc = 0, ack_cyc = 0, pix_cyc = 0, tick_cnt = 0, fd_cnt = 0;
  logic mute = 1'b0;
  logic ok, found;

  always #5 clk = ~clk;

  panel_scan #(.WIDTH(4), .HEIGHT(2), .TICK_DIV(3), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .bgRed(bgRed), .bgGreen(bgGreen), .bgBlue(bgBlue),
    .panelValid(panelValid), .panelTick(panelTick), .panelX(panelX), .panelY(panelY),
    .panelAck(panelAck), .panelValidOut(panelValidOut), .panelReady(panelReady),
    .panelRed(panelRed), .panelGreen(panelGreen), .panelBlue(panelBlue), .panelAlpha(panelAlpha),
    .pixValid(pixValid), .pixReady(pixReady), .pixX(pixX), .pixY(pixY),
    .pixRed(pixRed), .pixGreen(pixGreen), .pixBlue(pixBlue),
    .pixTimeout(pixTimeout), .frameDone(frameDone)
  );

  // Panel responder: answers a non-tick request one cycle later, ack clears it.
  always @(posedge clk) begin
    if (panelAck) panelValidOut <= 1'b0;
    if (panelValid && !panelTick && !mute) panelValidOut <= 1'b1;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (panelValid && !panelTick) req_cyc = cyc;
    if (panelValid && panelTick) tick_cnt++;
    if (panelAck) ack_cyc = cyc;
    if (frameDone) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] pk(input int x, input int y, input logic [7:0] r,
                                     input logic [7:0] g, input logic [7:0] b, input logic t);
    return {51'd0, 10'(x), 10'(y), r, g, b, t};
  endfunction

  function automatic logic [95:0] cur_pix();
    return {51'd0, pixX, pixY, pixRed, pixGreen, pixBlue, pixTimeout};
  endfunction

  function automatic logic [95:0] all_outs();
    return {26'd0, panelValid, panelTick, panelX, panelY, panelAck, pixValid,
            pixX, pixY, pixRed, pixGreen, pixBlue, pixTimeout, frameDone};
  endfunction

  task automatic wait_pix();
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pixValid) begin
        ok = 1'b1;
        pix_cyc = cyc;
        break;
      end
    end
    chk("pix_arrives", ok, 1'b1);
  endtask

  task automatic accept_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), '0);
    rst = 1'b0;
    enable = 1'b1;

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        wait_pix();
        chk($sformatf("frame%0d_pix%0d", f, i), cur_pix(), pk(i % 4, i / 4, 8'h00, 8'h10, 8'h00, 1'b0));
        chk($sformatf("frameDone_f%0d_p%0d", f, i), frameDone, (i == 7));
        if (f == 0 && i == 0) chk("req_to_pix_latency", pix_cyc - req_cyc, 3);
        if (f == 2 && i == 7) panelReady = 1'b0;
        accept_step();
      end
      chk($sformatf("frame_count_f%0d", f), fd_cnt, f + 1);
      if (f < 2) chk($sformatf("no_tick_f%0d", f), tick_cnt, 0);
    end

    for (int k = 0; k < 5; k++) begin
      chk("tick_held_not_ready", panelValid, 1'b0);
      @(negedge clk);
    end
    panelReady = 1'b1;
    panelRed = 8'hAA; panelGreen = 8'hAA; panelBlue = 8'hAA; panelAlpha = 8'h00;
    bgRed = 8'hFF; bgGreen = 8'h00; bgBlue = 8'h80;
    #1;
    chk("tick_pulse", {panelValid, panelTick}, 2'b11);
    @(negedge clk);
    chk("tick_count", tick_cnt, 1);

    wait_pix();
    chk("alpha0_is_bg", cur_pix(), pk(0, 0, 8'hFF, 8'h00, 8'h80, 1'b0));
    accept_step();
    panelRed = 8'hFF; panelGreen = 8'hFF; panelBlue = 8'hFF; panelAlpha = 8'h80;
    bgRed = 8'h00; bgGreen = 8'h00; bgBlue = 8'h00;

    wait_pix();
    chk("alpha80_half", cur_pix(), pk(1, 0, 8'h80, 8'h80, 8'h80, 1'b0));
    accept_step();
    panelRed = 8'hC0; panelGreen = 8'h00; panelBlue = 8'hFF; panelAlpha = 8'h40;
    bgRed = 8'h10; bgGreen = 8'hFF; bgBlue = 8'h00;
    pixReady = 1'b0;

    wait_pix();
    chk("alpha40_mix", cur_pix(), pk(2, 0, 8'h3C, 8'hBF, 8'h40, 1'b0));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_ctl", {pixValid, panelValid}, 2'b10);
      chk("stall_data", cur_pix(), pk(2, 0, 8'h3C, 8'hBF, 8'h40, 1'b0));
    end
    pixReady = 1'b1;
    accept_step();
    chk("valid_drops_after_accept", pixValid, 1'b0);
    mute = 1'b1;

    wait_pix();
    chk("timeout_bg", cur_pix(), pk(3, 0, 8'h10, 8'hFF, 8'h00, 1'b1));
    chk("timeout_ack_latency", ack_cyc - req_cyc, 16);
    accept_step();
    mute = 1'b0;
    enable = 1'b0;

    wait_pix();
    chk("disable_pixel_completes", cur_pix(), pk(0, 1, 8'h3C, 8'hBF, 8'h40, 1'b0));
    accept_step();
    for (int k = 0; k < 8; k++) begin
      chk("disabled_quiet", {panelValid, pixValid}, 2'b00);
      @(negedge clk);
    end
    enable = 1'b1;

    wait_pix();
    chk("resume_position", cur_pix(), pk(1, 1, 8'h3C, 8'hBF, 8'h40, 1'b0));
    accept_step();
    mute = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", all_outs(), '0);
    @(negedge clk);
    rst = 1'b0;
    mute = 1'b0;

    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (panelValid) begin
        found = 1'b1;
        break;
      end
    end
    chk("restart_request", found, 1'b1);
    chk("restart_position", {panelX, panelY}, 20'd0);
    wait_pix();
    chk("restart_pixel", cur_pix(), pk(0, 0, 8'h3C, 8'hBF, 8'h40, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/panel_scan.md
Name: panel_scan

Overview:
- Initiator and consumer for the panel generator protocol: valid/tick/x/y/ack out, validOut/ready/RGBA in.
- Walks x,y over the frame, requests one pixel at a time from a panel, and captures the returned RGBA.
- Alpha-blends the captured colour over a background colour and streams the pixel downstream to the LED driver over a valid/ready handshake.
- Issues the panel animation tick at frame boundaries.

Parameters:
- WIDTH, 64, pixels per row (1..1024).
- HEIGHT, 32, rows per frame (1..1024).
- TICK_DIV, 1, frames per panel tick (1..255).
- TIMEOUT, 15, max cycles to wait for panel response before substituting background.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  scanning permitted; sampled only when entering REQ
- bgRed, bgGreen, bgBlue  in  8 each  background colour
- panelValid  out  1  request strobe to panel (panel's valid)
- panelTick  out  1  tick qualifier, meaningful only with panelValid
- panelX, panelY  out  10 each  requested coordinate
- panelAck  out  1  clears panel's validOut
- panelValidOut  in  1  panel response valid
- panelReady  in  1  panel can accept a request
- panelRed, panelGreen, panelBlue, panelAlpha  in  8 each  panel colour
- pixValid  out  1  downstream pixel valid
- pixReady  in  1  downstream accept
- pixX, pixY  out  10 each  pixel coordinate
- pixRed, pixGreen, pixBlue  out  8 each  blended colour
- pixTimeout  out  1  pixel is background substitute
- frameDone  out  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- Reset: all outputs 0; x=y=0; frame counter 0; state IDLE.
- States: IDLE, REQ, WAIT, ACK, OUT, TICK.
- IDLE -> REQ when enable=1.
- REQ: when panelReady=1, assert panelValid=1, panelTick=0, panelX/Y=x,y for exactly one cycle, then -> WAIT. If panelReady=0, stay in REQ with panelValid=0.
- WAIT: panelValid=0 always, because a request coincident with an ack would re-set the panel's validOut.
  - Count cycles starting at 1.
  - panelValidOut=1 -> ACK, capturing RGBA.
  - If the count reaches TIMEOUT with no response -> ACK with timeout flag, using colour = bg and alpha = 0.
- ACK:
  - panelAck=1 for one cycle (also on timeout, which is harmless).
  - Register blend result, pixX/Y, and pixTimeout.
  - -> OUT.
- Blend, per channel, c=panel, b=bg, a=alpha, 17-bit intermediate:
  - t = c*a + b*(255-a) + 128
  - out = (t + (t>>8)) >> 8, truncated to 8 bits
  - a=255 gives out=c exactly; a=0 gives out=b exactly.
- OUT: pixValid=1 with data held stable until pixReady=1. On the accept cycle, pixValid drops the next cycle.
  - Advance x; at x=WIDTH-1, wrap x=0 and advance y.
  - At x=WIDTH-1, y=HEIGHT-1:
    - wrap y=0 and pulse frameDone;
    - increment the frame counter;
    - if it reaches TICK_DIV, clear it and -> TICK; else -> IDLE.
  - Otherwise -> REQ if enable=1, else IDLE.
- TICK: when panelReady=1, assert panelValid=1 and panelTick=1 for one cycle, expecting no response, then -> IDLE.
- Latency: request to pixValid is minimum 3 cycles (REQ, WAIT with response on the first cycle, ACK); pixValid is asserted in the 4th cycle.
- enable deassert mid-pixel: the current pixel completes fully (through OUT); scanning stops at the next REQ entry. Position is retained; no restart from 0.
- panelValidOut already high on WAIT entry (stale): accepted as the response.
- Reset mid-operation: immediate return to reset values; panel may be left with validOut=1 and is cleared by the first ack.
- pixReady held high: throughput 1 pixel per 4 cycles.

Decomposition:
- Shared package panel_pkg:
  - coordinate width constant (10);
  - colour width constant (8);
  - scanner state encoding localparams.
- One natural sub-module: panel_blend8 — combinational single-channel alpha blend, instantiated 3x, registered in ACK by panel_scan.

Test Plan:
- WIDTH=4, HEIGHT=2, stub panel returns RGBA=(0,0x10,0,0xFF) one cycle after valid, bg=(0x20,0x20,0x20), pixReady=1 -> 8 pixels with (0x00,0x10,0x00), coords (0,0)..(3,1) in raster order; frameDone on 8th accept; one tick cycle (panelValid=1, panelTick=1) follows.
- Alpha=0x00, panel colour 0xAA, bg=(0xFF,0x00,0x80) -> pix=(0xFF,0x00,0x80). Alpha=0x80, c=0xFF, b=0x00 -> t=32768, out=0x80.
- Stub panel never responds, TIMEOUT=15 -> panelAck pulses after 15 WAIT cycles; pix = bg with pixTimeout=1; scan advances to the next x.
- pixReady low for 10 cycles at pixel (2,0) -> pixValid and data stable for all 10 cycles; no new panelValid issued; advances only after the accept.
- TICK_DIV=3 -> panelTick pulse only after frames 3, 6; panelReady=0 during TICK holds panelValid low until ready.
- Assert rst during WAIT -> all outputs 0 asynchronously; after release with enable=1, the first request is at (0,0).
